// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver; ip_Rx_Serial in, op_Rx_Byte/op_Rx_DV on a good frame, op_Rx_Frame_Err on a low stop bit, op_Rx_Busy outside IDLE
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       ip_Clock,
  input  logic       ip_Reset,
  input  logic       ip_Rx_Serial,
  output logic       op_Rx_DV,
  output logic [7:0] op_Rx_Byte,
  output logic       op_Rx_Frame_Err,
  output logic       op_Rx_Busy
);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [7:0] cnt, cnt_n, sh, sh_n, byte_n;
  logic [2:0] idx, idx_n;
  logic dv_n, fe_n;
  always_ff @(posedge ip_Clock) begin
    if (ip_Reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      op_Rx_Byte <= '0;
      op_Rx_DV <= 1'b0;
      op_Rx_Frame_Err <= 1'b0;
    end else begin
      rx_m <= ip_Rx_Serial;
      rx_s <= rx_m;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      op_Rx_Byte <= byte_n;
      op_Rx_DV <= dv_n;
      op_Rx_Frame_Err <= fe_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    byte_n = op_Rx_Byte;
    dv_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: begin
        cnt_n = (cnt == HALF) ? '0 : cnt + 8'd1;
        state_n = (cnt != HALF) ? START : (rx_s ? IDLE : DATA);
      end
      DATA: begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 8'd1;
        if (cnt == LAST) begin
          sh_n[idx] = rx_s;
          idx_n = idx + 3'd1;
          state_n = (idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 8'd1;
        if (cnt == LAST) begin
          byte_n = rx_s ? sh : op_Rx_Byte;
          dv_n = rx_s;
          fe_n = !rx_s;
          state_n = rx_s ? CLEANUP : WAIT_HIGH;
        end
      end
      CLEANUP: state_n = IDLE;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
  assign op_Rx_Busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and directed checks of uart_rx at 104 and 4 clocks per bit
module tb_uart_rx;
  localparam int CPB = 104;
  localparam int CPB_B = 4;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_a = 1'b1, ser_b = 1'b1;
  logic dv_a, fe_a, busy_a, dv_b, fe_b, busy_b;
  logic [7:0] byte_a, byte_b;
  int cyc = 0, start_cyc = 0;
  int n_total = 0, n_pass = 0;
  int dv_cnt_a = 0, fe_cnt_a = 0, busy_cnt_a = 0, proto_a = 0;
  int dv_cnt_b = 0, fe_cnt_b = 0, proto_b = 0;
  logic dv_a_q = 1'b0, fe_a_q = 1'b0, dv_b_q = 1'b0, fe_b_q = 1'b0;
  logic [7:0] q_a[$], q_b[$];
  int dvt_a[$];
  vec_t vecs[7];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut_a (
    .ip_Clock(clk), .ip_Reset(rst), .ip_Rx_Serial(ser_a),
    .op_Rx_DV(dv_a), .op_Rx_Byte(byte_a), .op_Rx_Frame_Err(fe_a), .op_Rx_Busy(busy_a)
  );
  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .ip_Clock(clk), .ip_Reset(rst), .ip_Rx_Serial(ser_b),
    .op_Rx_DV(dv_b), .op_Rx_Byte(byte_b), .op_Rx_Frame_Err(fe_b), .op_Rx_Busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dv_a) begin
        dv_cnt_a <= dv_cnt_a + 1;
        q_a.push_back(byte_a);
        dvt_a.push_back(cyc);
      end
      if (fe_a) fe_cnt_a <= fe_cnt_a + 1;
      if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
      if ((dv_a && fe_a) || (dv_a && dv_a_q) || (fe_a && fe_a_q)) proto_a <= proto_a + 1;
      if (dv_b) begin
        dv_cnt_b <= dv_cnt_b + 1;
        q_b.push_back(byte_b);
      end
      if (fe_b) fe_cnt_b <= fe_cnt_b + 1;
      if ((dv_b && fe_b) || (dv_b && dv_b_q) || (fe_b && fe_b_q)) proto_b <= proto_b + 1;
    end
    dv_a_q <= dv_a;
    fe_a_q <= fe_a;
    dv_b_q <= dv_b;
    fe_b_q <= fe_b;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) ser_a = v;
    else ser_b = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int sel, input int cpb, input logic [7:0] d, input logic stop);
    set_line(sel, 1'b0);
    start_cyc = cyc;
    idle(cpb);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      idle(cpb);
    end
    set_line(sel, stop);
    idle(cpb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, f0, b0, n0, errs;
    logic [7:0] p;
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[5] = '{8'h5A, 1'b0, 0, 1, 8'h81};
    vecs[6] = '{8'h96, 1'b1, 1, 0, 8'h96};
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_byte", int'(byte_a), 0);
    check("reset_dv", int'(dv_a), 0);
    check("reset_fe", int'(fe_a), 0);
    check("reset_busy", int'(busy_a), 0);
    check("reset_busy_b", int'(busy_b), 0);

    for (int i = 0; i < 7; i++) begin
      d0 = dv_cnt_a;
      f0 = fe_cnt_a;
      send(0, CPB, vecs[i].data, vecs[i].stop);
      set_line(0, 1'b1);
      idle(2 * CPB);
      check($sformatf("vec%0d_dv", i), dv_cnt_a - d0, vecs[i].exp_dv);
      check($sformatf("vec%0d_fe", i), fe_cnt_a - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d_byte", i), int'(byte_a), int'(vecs[i].exp_byte));
      check($sformatf("vec%0d_busy", i), int'(busy_a), 0);
      if (vecs[i].exp_dv == 1 && dvt_a.size() > 0)
        check_rng($sformatf("vec%0d_latency", i), dvt_a[$] - start_cyc, 9 * CPB, (19 * CPB) / 2 + 4);
    end

    d0 = dv_cnt_a;
    f0 = fe_cnt_a;
    b0 = busy_cnt_a;
    set_line(0, 1'b0);
    idle(20);
    set_line(0, 1'b1);
    idle(200);
    check("glitch_dv", dv_cnt_a - d0, 0);
    check("glitch_fe", fe_cnt_a - f0, 0);
    check_rng("glitch_busy_cycles", busy_cnt_a - b0, 1, 55);
    check("glitch_busy_end", int'(busy_a), 0);

    d0 = dv_cnt_a;
    f0 = fe_cnt_a;
    send(0, CPB, 8'h3C, 1'b0);
    idle(3 * CPB);
    check("break_fe", fe_cnt_a - f0, 1);
    check("break_dv", dv_cnt_a - d0, 0);
    check("break_byte", int'(byte_a), 8'h96);
    check("break_busy_low_line", int'(busy_a), 1);
    set_line(0, 1'b1);
    idle(10);
    check("break_busy_after_high", int'(busy_a), 0);
    check("break_fe_after_high", fe_cnt_a - f0, 1);
    check("break_dv_after_high", dv_cnt_a - d0, 0);

    n0 = q_a.size();
    send(0, CPB, 8'h00, 1'b1);
    send(0, CPB, 8'hFF, 1'b1);
    send(0, CPB, 8'h81, 1'b1);
    set_line(0, 1'b1);
    idle(2 * CPB);
    check("b2b_count", q_a.size() - n0, 3);
    if (q_a.size() - n0 == 3) begin
      check("b2b_byte0", int'(q_a[n0]), 8'h00);
      check("b2b_byte1", int'(q_a[n0 + 1]), 8'hFF);
      check("b2b_byte2", int'(q_a[n0 + 2]), 8'h81);
      check_rng("b2b_gap01", dvt_a[n0 + 1] - dvt_a[n0], 10 * CPB - 1, 10 * CPB + 1);
      check_rng("b2b_gap12", dvt_a[n0 + 2] - dvt_a[n0 + 1], 10 * CPB - 1, 10 * CPB + 1);
    end

    d0 = dv_cnt_a;
    f0 = fe_cnt_a;
    p = 8'h5A;
    set_line(0, 1'b0);
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      set_line(0, p[i]);
      idle(CPB);
    end
    set_line(0, p[4]);
    idle(CPB / 2);
    rst = 1'b1;
    idle(1);
    check("midreset_busy", int'(busy_a), 0);
    check("midreset_byte", int'(byte_a), 0);
    rst = 1'b0;
    set_line(0, 1'b1);
    idle(12 * CPB);
    check("midreset_dv", dv_cnt_a - d0, 0);
    check("midreset_fe", fe_cnt_a - f0, 0);
    send(0, CPB, 8'h96, 1'b1);
    set_line(0, 1'b1);
    idle(2 * CPB);
    check("after_reset_dv", dv_cnt_a - d0, 1);
    check("after_reset_byte", int'(byte_a), 8'h96);

    n0 = q_b.size();
    for (int i = 0; i < 256; i++) send(1, CPB_B, 8'(i), 1'b1);
    set_line(1, 1'b1);
    idle(5 * CPB_B);
    check("loop_count", q_b.size() - n0, 256);
    errs = 0;
    for (int j = 0; j < 256; j++)
      if (n0 + j >= q_b.size() || q_b[n0 + j] != 8'(j)) errs++;
    check("loop_byte_errors", errs, 0);
    check("loop_fe", fe_cnt_b, 0);
    check("protocol_a", proto_a, 0);
    check("protocol_b", proto_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, giving ip_Clock cycles per UART bit; the legal range is 4..255.
REQ-002 The block SHALL have port ip_Clock, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-003 The block SHALL have port ip_Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ip_Rx_Serial, input, 1 bit: the asynchronous serial line, 8N1, idle high.
REQ-005 The block SHALL have port op_Rx_DV, output, 1 bit: one-cycle pulse that marks op_Rx_Byte as newly valid.
REQ-006 The block SHALL have port op_Rx_Byte, output, 8 bits: the last correctly framed byte received.
REQ-007 The block SHALL have port op_Rx_Frame_Err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port op_Rx_Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 ip_Rx_Serial SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the second flop (rx_s).
REQ-010 The FSM SHALL have the states IDLE, START, DATA, STOP, CLEANUP and WAIT_HIGH, held in 3-bit encoding; an unused encoding SHALL go to IDLE.
REQ-011 IDLE: the clock counter and bit index SHALL be 0; rx_s==0 SHALL go to START.
REQ-012 START: the counter SHALL increment until it reaches (CLKS_PER_BIT-1)/2 (integer division; 51 at the default).
- At that count, rx_s==0 SHALL go to DATA with the counter cleared.
- At that count, rx_s==1 is a glitch and SHALL go to IDLE with no output pulse.
REQ-013 DATA: the counter SHALL count 0..CLKS_PER_BIT-1.
- At CLKS_PER_BIT-1, rx_s SHALL be stored into the shift register at the bit index (LSB first) and the counter SHALL clear.
- Bit index 7 SHALL go to STOP; otherwise the index SHALL increment.
REQ-014 STOP: the same CLKS_PER_BIT-1 wait SHALL apply; at that count rx_s SHALL be sampled.
- rx_s==1: op_Rx_Byte SHALL load the shift register and op_Rx_DV SHALL pulse on the next edge; the FSM SHALL go to CLEANUP.
- rx_s==0: op_Rx_Frame_Err SHALL pulse, op_Rx_Byte SHALL be unchanged and op_Rx_DV SHALL stay low; the FSM SHALL go to WAIT_HIGH.
REQ-015 CLEANUP: the FSM SHALL stay one cycle, clear the pulses and go to IDLE.
REQ-016 WAIT_HIGH: the FSM SHALL remain until rx_s==1, then go to IDLE. A break (line held low) SHALL therefore produce exactly one Frame_Err and no further starts.
REQ-017 op_Rx_DV and op_Rx_Frame_Err SHALL each be high for exactly one cycle per frame and SHALL never be high together.
REQ-018 Sampling points SHALL be at start-edge + 2 sync cycles + (CLKS_PER_BIT-1)/2 + k*CLKS_PER_BIT, for k=1..9, with ±1 cycle tolerance.
REQ-019 op_Rx_DV SHALL rise no later than 9.5*CLKS_PER_BIT + 4 cycles after the falling start edge on ip_Rx_Serial.
REQ-020 A start edge arriving in CLEANUP SHALL be detected in the following IDLE cycle, so back-to-back frames with a one-bit stop are received without loss.
REQ-021 Counter width SHALL be 8 bits; the counter SHALL never wrap within a bit period for legal CLKS_PER_BIT.

Reset
REQ-022 With ip_Reset high at a rising edge, all of the following SHALL hold on the next cycle:
- FSM in IDLE, counter=0, bit index=0.
- Synchronizer flops = 1.
- op_Rx_Byte=8'h00, op_Rx_DV=0, op_Rx_Frame_Err=0, op_Rx_Busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no DV or Frame_Err pulse.
- After release, reception SHALL resume only at the next falling edge.
- If the line is low at release, that low level SHALL be treated as a start condition.
REQ-024 Reset SHALL take priority over every FSM transition.

Verification
REQ-025 Frame 0xA5 at CLKS_PER_BIT=104 -> one DV pulse, op_Rx_Byte=8'hA5, Frame_Err never high, Busy low after CLEANUP.
REQ-026 Low glitch of 20 cycles on an idle line -> no DV, no Frame_Err; Busy high for ≤55 cycles, then IDLE.
REQ-027 Frame 0x3C with stop bit forced 0, line then held low for 3 bit times -> one Frame_Err pulse, op_Rx_Byte keeps its prior value, no new start until the line returns high.
REQ-028 Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three DV pulses with bytes in order, exactly 10*CLKS_PER_BIT ±1 cycles apart.
REQ-029 Reset pulsed during data bit 4 of 0x5A, then a clean 0x96 -> no pulse for 0x5A, one DV with 8'h96.
REQ-030 Loopback from the team's uart_tx transmitter, 256 bytes 0x00..0xFF, CLKS_PER_BIT=4 and 104 -> every byte received correctly, zero Frame_Err.
